// File: rtl/demux_pkg.sv
// Shared types and default sizing for the stream demultiplexer.
// SEL_WIDTH is derived from the channel count.
package demux_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_CH     = 8;
  localparam int DEF_SEL_WIDTH  = $clog2(DEF_NUM_CH);
  localparam int DEF_CNT_WIDTH  = 16;

  typedef logic [DEF_DATA_WIDTH-1:0] data_t;
  typedef logic [DEF_SEL_WIDTH-1:0]  sel_t;
endpackage

// File: rtl/demux_stream_if.sv
// Source-side and sink-side handshake bundle of the demultiplexer.
// slave faces the demux, master faces source and sinks.
interface demux_stream_if
  import demux_pkg::*;
#(
  parameter int DW  = DEF_DATA_WIDTH,
  parameter int NCH = DEF_NUM_CH,
  parameter int SW  = DEF_SEL_WIDTH,
  parameter int CW  = DEF_CNT_WIDTH
);
  logic          valid_i;
  logic          ready_o;
  logic [SW-1:0] selector_i;
  logic [DW-1:0] channel_in_i;
  logic [NCH-1:0] valid_o;
  logic [NCH-1:0] ready_i;
  logic [DW-1:0] channel_out_o [NCH];
  logic [CW-1:0] drop_cnt_o;

  modport slave (
    input  valid_i, selector_i, channel_in_i, ready_i,
    output ready_o, valid_o, channel_out_o, drop_cnt_o
  );

  modport master (
    output valid_i, selector_i, channel_in_i, ready_i,
    input  ready_o, valid_o, channel_out_o, drop_cnt_o
  );
endinterface

// File: rtl/demux_slot.sv
// One-entry output register slice; a load in the same cycle
// as a drain wins, so a channel can sustain one beat per cycle.
module demux_slot
  import demux_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (load_i) begin
      r_valid <= 1'b1;
      r_data  <= data_i;
    end else if (r_valid && ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign valid_o = r_valid;
  assign data_o  = r_data;
endmodule

// File: rtl/demux_stream.sv
// Registered 1-to-NUM_CH stream demultiplexer with per-channel
// one-entry slots and a saturating counter of misrouted beats.
module demux_stream
  import demux_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int SEL_WIDTH  = DEF_SEL_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic clk_i,
  input  logic arstn_i,
  demux_stream_if.slave s
);
  logic                  w_busy;
  logic                  w_ready;
  logic                  w_acc;
  logic                  w_in_range;
  logic                  w_drop;
  logic [NUM_CH-1:0]     w_load;
  logic [NUM_CH-1:0]     w_valid;
  logic [DATA_WIDTH-1:0] w_data [NUM_CH];
  logic [CNT_WIDTH-1:0]  r_drop_cnt;

  assign w_in_range =
    {1'b0, s.selector_i} < (SEL_WIDTH+1)'(NUM_CH);

  // ready_i -> ready_o is a deliberate combinational path:
  // a full slot accepts when its sink drains in the same cycle.
  always_comb begin
    w_busy = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (s.selector_i == SEL_WIDTH'(k))
        w_busy = w_valid[k] && !s.ready_i[k];
    end
  end

  assign w_ready = !w_busy;
  assign w_acc   = s.valid_i && w_ready;
  assign w_drop  = w_acc && !w_in_range;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    assign w_load[k] =
      w_acc && (s.selector_i == SEL_WIDTH'(k));

    demux_slot #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_slot (
      .clk_i   (clk_i),
      .arstn_i (arstn_i),
      .load_i  (w_load[k]),
      .data_i  (s.channel_in_i),
      .ready_i (s.ready_i[k]),
      .valid_o (w_valid[k]),
      .data_o  (w_data[k])
    );
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i)
      r_drop_cnt <= '0;
    else if (w_drop && (r_drop_cnt != '1))
      r_drop_cnt <= r_drop_cnt + 1'b1;
  end

  assign s.ready_o       = w_ready;
  assign s.valid_o       = w_valid;
  assign s.channel_out_o = w_data;
  assign s.drop_cnt_o    = r_drop_cnt;
endmodule

// File: tb/tb_demux_stream.sv
// Self-checking bench for demux_stream: directed scenarios plus
// randomized traffic against a per-channel queue model.
module tb_demux_stream;
  import demux_pkg::*;

  logic clk;
  logic arstn;

  demux_stream_if #(.DW(32), .NCH(8), .SW(3), .CW(16)) bus ();
  demux_stream_if #(.DW(32), .NCH(6), .SW(3), .CW(2))  bus6 ();

  demux_stream #(
    .DATA_WIDTH(32), .NUM_CH(8), .SEL_WIDTH(3), .CNT_WIDTH(16)
  ) dut (
    .clk_i(clk), .arstn_i(arstn), .s(bus)
  );

  demux_stream #(
    .DATA_WIDTH(32), .NUM_CH(6), .SEL_WIDTH(3), .CNT_WIDTH(2)
  ) dut6 (
    .clk_i(clk), .arstn_i(arstn), .s(bus6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assert property (@(posedge clk) disable iff (!arstn)
    (bus.valid_i && !bus.ready_o) |=>
    (bus.valid_i && $stable(bus.selector_i) && $stable(bus.channel_in_i)))
    else $error("source rule broken");

  int n_pass = 0;
  int n_total = 0;

  // Reference model: each channel holds at most one pending beat.
  bit    m_full [8];
  data_t m_data [8];
  data_t exp_q [8][$];
  data_t got_q [8][$];
  bit    exp_ready;
  bit    obs_ready;

  function automatic void m_reset();
    for (int k = 0; k < 8; k++) begin
      m_full[k] = 1'b0;
      m_data[k] = '0;
      exp_q[k].delete();
      got_q[k].delete();
    end
  endfunction

  function automatic logic [7:0] m_vec();
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[k] = m_full[k];
    return v;
  endfunction

  function automatic void clear_logs();
    for (int k = 0; k < 8; k++) begin
      exp_q[k].delete();
      got_q[k].delete();
    end
  endfunction

  task automatic drive(input bit v, input logic [2:0] sel,
                       input data_t d, input logic [7:0] rdy);
    bit acc;
    @(negedge clk);
    bus.valid_i      = v;
    bus.selector_i   = sel;
    bus.channel_in_i = d;
    bus.ready_i      = rdy;
    #1;
    exp_ready = !(m_full[sel] && !rdy[sel]);
    obs_ready = bus.ready_o;
    for (int k = 0; k < 8; k++)
      if (bus.valid_o[k] && rdy[k])
        got_q[k].push_back(bus.channel_out_o[k]);
    @(posedge clk);
    acc = v && exp_ready;
    for (int k = 0; k < 8; k++) begin
      if (m_full[k] && rdy[k]) exp_q[k].push_back(m_data[k]);
      if (acc && sel == 3'(k)) begin
        m_full[k] = 1'b1;
        m_data[k] = d;
      end else if (m_full[k] && rdy[k]) begin
        m_full[k] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    arstn = 1'b0;
    bus.valid_i = 1'b0; bus.selector_i = '0;
    bus.channel_in_i = '0; bus.ready_i = '0;
    bus6.valid_i = 1'b0; bus6.selector_i = '0;
    bus6.channel_in_i = '0; bus6.ready_i = '1;
    m_reset();
    #20;
    n_total++;
    if (bus.valid_o !== 8'h00)
      $display("FAIL reset_valid got %h want 00", bus.valid_o);
    else n_pass++;
    n_total++;
    if (bus.ready_o !== 1'b1)
      $display("FAIL reset_ready got %b want 1", bus.ready_o);
    else n_pass++;
    n_total++;
    if (bus.drop_cnt_o !== 16'd0)
      $display("FAIL reset_drop got %0d want 0", bus.drop_cnt_o);
    else n_pass++;
    n_total++;
    if (bus6.drop_cnt_o !== 2'd0 || bus6.valid_o !== 6'd0)
      $display("FAIL reset_dut6 got %0d/%h want 0/00",
               bus6.drop_cnt_o, bus6.valid_o);
    else n_pass++;
    for (int k = 0; k < 8; k++) begin
      n_total++;
      if (bus.channel_out_o[k] !== 32'h0)
        $display("FAIL reset_data[%0d] got %h want 0",
                 k, bus.channel_out_o[k]);
      else n_pass++;
    end
    @(negedge clk);
    arstn = 1'b1;
  endtask

  task automatic test_sweep();
    data_t d;
    for (int s = 0; s < 8; s++) begin
      d = 32'hA000_0000 + 32'(s);
      drive(1'b1, 3'(s), d, 8'hFF);
      n_total++;
      if (bus.valid_o !== 8'(1 << s))
        $display("FAIL sweep_valid[%0d] got %h want %h",
                 s, bus.valid_o, 8'(1 << s));
      else n_pass++;
      n_total++;
      if (bus.channel_out_o[s] !== d)
        $display("FAIL sweep_data[%0d] got %h want %h",
                 s, bus.channel_out_o[s], d);
      else n_pass++;
    end
    drive(1'b0, 3'd0, '0, 8'hFF);
    n_total++;
    if (bus.valid_o !== 8'h00)
      $display("FAIL sweep_idle got %h want 00", bus.valid_o);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    clear_logs();
    drive(1'b1, 3'd3, 32'h1111_1111, 8'hF7);
    n_total++;
    if (!bus.valid_o[3] || bus.channel_out_o[3] !== 32'h1111_1111)
      $display("FAIL bp_first got %b/%h want 1/11111111",
               bus.valid_o[3], bus.channel_out_o[3]);
    else n_pass++;
    drive(1'b1, 3'd3, 32'h2222_2222, 8'hF7);
    n_total++;
    if (obs_ready !== 1'b0)
      $display("FAIL bp_stall_ready got %b want 0", obs_ready);
    else n_pass++;
    n_total++;
    if (bus.channel_out_o[3] !== 32'h1111_1111)
      $display("FAIL bp_hold got %h want 11111111",
               bus.channel_out_o[3]);
    else n_pass++;
    drive(1'b1, 3'd3, 32'h2222_2222, 8'hFF);
    n_total++;
    if (obs_ready !== 1'b1)
      $display("FAIL bp_release_ready got %b want 1", obs_ready);
    else n_pass++;
    drive(1'b0, 3'd0, '0, 8'hFF);
    n_total++;
    if (bus.valid_o[3] !== 1'b0 ||
        bus.channel_out_o[3] !== 32'h2222_2222)
      $display("FAIL bp_drained got %b/%h want 0/22222222",
               bus.valid_o[3], bus.channel_out_o[3]);
    else n_pass++;
    n_total++;
    if (got_q[3].size() != 2 || got_q[3][0] !== 32'h1111_1111 ||
        got_q[3][1] !== 32'h2222_2222)
      $display("FAIL bp_order got %0d beats want 2 in order",
               got_q[3].size());
    else n_pass++;
  endtask

  task automatic test_isolation();
    drive(1'b1, 3'd3, 32'h3333_3333, 8'hF7);
    drive(1'b1, 3'd5, 32'h5555_5555, 8'hF7);
    n_total++;
    if (obs_ready !== 1'b1)
      $display("FAIL iso_ready got %b want 1", obs_ready);
    else n_pass++;
    n_total++;
    if (!bus.valid_o[5] || bus.channel_out_o[5] !== 32'h5555_5555)
      $display("FAIL iso_ch5 got %b/%h want 1/55555555",
               bus.valid_o[5], bus.channel_out_o[5]);
    else n_pass++;
    n_total++;
    if (!bus.valid_o[3] || bus.channel_out_o[3] !== 32'h3333_3333)
      $display("FAIL iso_ch3 got %b/%h want 1/33333333",
               bus.valid_o[3], bus.channel_out_o[3]);
    else n_pass++;
    drive(1'b0, 3'd0, '0, 8'hFF);
  endtask

  task automatic test_load_drain();
    data_t d;
    for (int i = 0; i < 6; i++) begin
      d = 32'hB000_0000 + 32'(i);
      drive(1'b1, 3'd1, d, 8'hFF);
      n_total++;
      if (obs_ready !== 1'b1 || bus.valid_o[1] !== 1'b1 ||
          bus.channel_out_o[1] !== d)
        $display("FAIL ld_beat%0d got %b/%b/%h want 1/1/%h",
                 i, obs_ready, bus.valid_o[1],
                 bus.channel_out_o[1], d);
      else n_pass++;
    end
    drive(1'b0, 3'd0, '0, 8'hFF);
  endtask

  task automatic test_random();
    bit hold = 1'b0;
    bit v;
    logic [2:0] s;
    data_t d;
    logic [7:0] r;
    clear_logs();
    for (int c = 0; c < 400; c++) begin
      if (!hold) begin
        v = ($urandom_range(0, 3) != 0);
        s = 3'($urandom_range(0, 7));
        d = $urandom;
      end
      r = 8'($urandom) | 8'($urandom);
      drive(v, s, d, r);
      hold = v && !exp_ready;
      n_total++;
      if (obs_ready !== exp_ready)
        $display("FAIL rnd_ready c%0d got %b want %b",
                 c, obs_ready, exp_ready);
      else n_pass++;
      n_total++;
      if (bus.valid_o !== m_vec())
        $display("FAIL rnd_valid c%0d got %h want %h",
                 c, bus.valid_o, m_vec());
      else n_pass++;
      for (int k = 0; k < 8; k++) begin
        n_total++;
        if (bus.channel_out_o[k] !== m_data[k])
          $display("FAIL rnd_data c%0d ch%0d got %h want %h",
                   c, k, bus.channel_out_o[k], m_data[k]);
        else n_pass++;
      end
    end
    drive(hold, s, d, 8'hFF);
    drive(1'b0, 3'd0, '0, 8'hFF);
    drive(1'b0, 3'd0, '0, 8'hFF);
    for (int k = 0; k < 8; k++) begin
      n_total++;
      if (got_q[k] != exp_q[k])
        $display("FAIL rnd_order ch%0d got %0d beats want %0d",
                 k, got_q[k].size(), exp_q[k].size());
      else n_pass++;
    end
    n_total++;
    if (bus.drop_cnt_o !== 16'd0)
      $display("FAIL rnd_drop got %0d want 0", bus.drop_cnt_o);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    drive(1'b1, 3'd2, 32'hC0FF_EE02, 8'hFB);
    n_total++;
    if (bus.valid_o[2] !== 1'b1)
      $display("FAIL ar_loaded got %b want 1", bus.valid_o[2]);
    else n_pass++;
    #2;
    arstn = 1'b0;
    bus.valid_i = 1'b0;
    #1;
    n_total++;
    if (bus.valid_o !== 8'h00 || bus.channel_out_o[2] !== 32'h0)
      $display("FAIL ar_immediate got %h/%h want 00/0",
               bus.valid_o, bus.channel_out_o[2]);
    else n_pass++;
    m_reset();
    @(negedge clk);
    arstn = 1'b1;
  endtask

  task automatic test_drops();
    logic [2:0] sels [5];
    int n = 0;
    int e;
    sels[0] = 3'd6; sels[1] = 3'd7; sels[2] = 3'd6;
    sels[3] = 3'd7; sels[4] = 3'd6;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus6.valid_i = 1'b1;
      bus6.selector_i = sels[i];
      bus6.channel_in_i = $urandom;
      bus6.ready_i = 6'h3F;
      #1;
      n_total++;
      if (bus6.ready_o !== 1'b1)
        $display("FAIL drop_ready%0d got %b want 1", i, bus6.ready_o);
      else n_pass++;
      @(posedge clk);
      #1;
      n++;
      e = (n > 3) ? 3 : n;
      n_total++;
      if (bus6.valid_o !== 6'h00 || bus6.drop_cnt_o !== 2'(e))
        $display("FAIL drop_cnt%0d got %h/%0d want 00/%0d",
                 i, bus6.valid_o, bus6.drop_cnt_o, e);
      else n_pass++;
    end
    @(negedge clk);
    bus6.valid_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_backpressure();
    test_isolation();
    test_load_drain();
    test_random();
    test_async_reset();
    test_drops();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
